// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative 32x32 signed multiply (radix-2 Booth) and signed
//               divide (restoring, on magnitudes) unit. One iteration per
//               clock, 32 iterations per operation, fixed latency.
//               Division follows MIPS semantics: the quotient truncates toward
//               zero and the remainder takes the sign of the dividend.
//               0x80000000 / -1 wraps to 0x80000000 with no flag.
// Ports       : i_clk        system clock, rising edge
//               i_rst_n      asynchronous active-low reset
//               i_start      operation request, sampled only in IDLE
//               i_op         0 = signed multiply, 1 = signed divide
//               i_a, i_b     operands (multiplicand/dividend, multiplier/divisor)
//               o_busy       operation in progress (MULT, DIV or DONE)
//               o_done       one-cycle result-valid pulse
//               o_div_zero   divide by zero, valid only with o_done
//               o_hi, o_lo   mult: product[63:32]/[31:0]; div: remainder/quotient
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_div_zero,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [5:0] c_LAST_ITER = 6'd31;

    state_t      r_state;
    state_t      w_next_state;

    logic [5:0]  r_cnt;
    // Shared datapath: mult uses {r_acc, r_mq, r_qm1} as the Booth register
    // with r_m as multiplicand; div uses r_acc as partial remainder, r_mq as
    // dividend shifting out / quotient shifting in, r_m as divisor magnitude.
    logic [31:0] r_acc;
    logic [31:0] r_mq;
    logic        r_qm1;
    logic [31:0] r_m;
    logic        r_neg_q;
    logic        r_neg_r;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;
    logic        r_div_zero;

    logic        w_last;
    logic        w_divz_start;
    logic        w_accept;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;

    logic [32:0] w_booth_sum;
    logic [31:0] w_booth_acc;
    logic [31:0] w_booth_mq;

    logic [32:0] w_div_shift;
    logic        w_div_ge;
    logic [31:0] w_div_rem;
    logic [31:0] w_div_quo;
    logic [31:0] w_rem_final;
    logic [31:0] w_quo_final;

    assign w_last       = (r_cnt == c_LAST_ITER);
    assign w_accept     = (r_state == S_IDLE) && i_start;
    assign w_divz_start = w_accept && i_op && (i_b == 32'd0);
    assign w_abs_a      = i_a[31] ? (~i_a + 32'd1) : i_a;
    assign w_abs_b      = i_b[31] ? (~i_b + 32'd1) : i_b;

    // ------------------------------------------------------------------
    // Booth step. The add/sub is done at 33 bits so a multiplicand of
    // 0x80000000 cannot overflow the accumulator; the shift then takes
    // the true sign from bit 32 of the sum.
    // ------------------------------------------------------------------
    always_comb begin
        w_booth_sum = {r_acc[31], r_acc};
        case ({r_mq[0], r_qm1})
            2'b01:   w_booth_sum = {r_acc[31], r_acc} + {r_m[31], r_m};
            2'b10:   w_booth_sum = {r_acc[31], r_acc} - {r_m[31], r_m};
            default: w_booth_sum = {r_acc[31], r_acc};
        endcase
    end

    assign w_booth_acc = w_booth_sum[32:1];
    assign w_booth_mq  = {w_booth_sum[0], r_mq[31:1]};

    // ------------------------------------------------------------------
    // Restoring division step on magnitudes. When the trial subtraction
    // succeeds the true difference is below 2^32, so the 32-bit wrapped
    // difference is exact.
    // ------------------------------------------------------------------
    assign w_div_shift = {r_acc, r_mq[31]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_m});
    assign w_div_rem   = w_div_ge ? (w_div_shift[31:0] - r_m) : w_div_shift[31:0];
    assign w_div_quo   = {r_mq[30:0], w_div_ge};

    // Sign restoration; negating 0x80000000 yields itself, giving the
    // required wrap for 0x80000000 / -1.
    assign w_quo_final = r_neg_q ? (~w_div_quo + 32'd1) : w_div_quo;
    assign w_rem_final = r_neg_r ? (~w_div_rem + 32'd1) : w_div_rem;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (!i_op) begin
                        w_next_state = S_MULT;
                    end else if (i_b == 32'd0) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_DIV;
                    end
                end
            end
            S_MULT:  if (w_last) w_next_state = S_DONE;
            S_DIV:   if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_busy     <= (w_next_state != S_IDLE);
            r_done     <= (w_next_state == S_DONE);
            r_div_zero <= w_divz_start;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= 6'd0;
            r_acc   <= 32'd0;
            r_mq    <= 32'd0;
            r_qm1   <= 1'b0;
            r_m     <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= 6'd0;
                        r_acc <= 32'd0;
                        r_qm1 <= 1'b0;
                        if (i_op) begin
                            r_mq    <= w_abs_a;
                            r_m     <= w_abs_b;
                            r_neg_q <= i_a[31] ^ i_b[31];
                            r_neg_r <= i_a[31];
                        end else begin
                            r_mq    <= i_b;
                            r_m     <= i_a;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end
                    end
                end
                S_MULT: begin
                    r_acc <= w_booth_acc;
                    r_mq  <= w_booth_mq;
                    r_qm1 <= r_mq[0];
                    r_cnt <= r_cnt + 6'd1;
                    if (w_last) begin
                        r_hi <= w_booth_acc;
                        r_lo <= w_booth_mq;
                    end
                end
                S_DIV: begin
                    r_acc <= w_div_rem;
                    r_mq  <= w_div_quo;
                    r_cnt <= r_cnt + 6'd1;
                    if (w_last) begin
                        r_hi <= w_rem_final;
                        r_lo <= w_quo_final;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_div_zero = r_div_zero;
    assign o_hi       = r_hi;
    assign o_lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit. Results are compared
//               against a 64-bit integer arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    // Last architecturally visible result, tracked by the model.
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_op       (op),
        .i_a        (a),
        .i_b        (b),
        .o_busy     (busy),
        .o_done     (done),
        .o_div_zero (div_zero),
        .o_hi       (hi),
        .o_lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain 64-bit integer arithmetic.
    function automatic void ref_model(input logic op_i, input logic [31:0] a_i,
                                      input logic [31:0] b_i,
                                      input logic [31:0] ph, input logic [31:0] pl,
                                      output logic [31:0] eh, output logic [31:0] el,
                                      output logic edz);
        longint sa, sb, p, q, r;
        sa  = longint'($signed(a_i));
        sb  = longint'($signed(b_i));
        edz = 1'b0;
        if (!op_i) begin
            p  = sa * sb;
            eh = p[63:32];
            el = p[31:0];
        end else if (b_i == 32'd0) begin
            eh  = ph;
            el  = pl;
            edz = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            eh = r[31:0];
            el = q[31:0];
        end
    endfunction

    // Drives one operation and observes it; no checking here.
    // lat = cycles from start edge until done is seen (-1 on timeout).
    task automatic do_op(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                         output int lat, output logic [31:0] oh, output logic [31:0] ol,
                         output logic odz, output logic busy_ok, output logic hold_ok,
                         output logic idle_ok);
        logic [31:0] h0, l0;
        @(negedge clk);
        h0 = hi;
        l0 = lo;
        start = 1'b1;
        op    = op_i;
        a     = a_i;
        b     = b_i;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 1'($urandom);
        a     = $urandom;
        b     = $urandom;
        lat     = -1;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        oh = 32'd0; ol = 32'd0; odz = 1'b0;
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = c;
                oh  = hi;
                ol  = lo;
                odz = div_zero;
                break;
            end
            if (hi !== h0 || lo !== l0 || div_zero !== 1'b0) hold_ok = 1'b0;
        end
        @(posedge clk);
        #1;
        idle_ok = !busy && !done && !div_zero;
    endtask

    task automatic test_reset();
        start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
        rst_n = 1'b0;
        #3;
        n_tests++;
        if ({busy, done, div_zero} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done/dz=%b want 000", {busy, done, div_zero});
        end
        n_tests++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_hilo: hi=%h lo=%h want 0/0", hi, lo);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_directed_mult();
        int lat; logic [31:0] oh, ol; logic odz, bok, hok, iok;
        do_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat, oh, ol, odz, bok, hok, iok);
        n_tests++;
        if (lat !== 32) begin n_fail++; $display("FAIL mult_latency: got %0d want 32", lat); end
        n_tests++;
        if (oh !== 32'hFFFF_FFFF || ol !== 32'hFFFF_FFEB) begin
            n_fail++;
            $display("FAIL mult_7x-3: hi=%h lo=%h want ffffffff/ffffffeb", oh, ol);
        end
        n_tests++;
        if (!bok || !hok || odz !== 1'b0) begin
            n_fail++;
            $display("FAIL mult_busy_hold: busy_ok=%b hold_ok=%b dz=%b want 1/1/0", bok, hok, odz);
        end
        n_tests++;
        if (!iok) begin n_fail++; $display("FAIL mult_done_one_cycle: idle_ok=%b want 1", iok); end
        m_hi = oh; m_lo = ol;
    endtask

    task automatic test_directed_div();
        logic [31:0] da [3];
        logic [31:0] db [3];
        logic [31:0] eq [3];
        logic [31:0] er [3];
        int lat; logic [31:0] oh, ol; logic odz, bok, hok, iok;
        da[0] = 32'd7;           db[0] = 32'hFFFF_FFFE; eq[0] = 32'hFFFF_FFFD; er[0] = 32'h0000_0001;
        da[1] = 32'hFFFF_FFF9;   db[1] = 32'd2;         eq[1] = 32'hFFFF_FFFD; er[1] = 32'hFFFF_FFFF;
        da[2] = 32'hFFFF_FFF9;   db[2] = 32'hFFFF_FFFE; eq[2] = 32'h0000_0003; er[2] = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            do_op(1'b1, da[i], db[i], lat, oh, ol, odz, bok, hok, iok);
            n_tests++;
            if (lat !== 32 || ol !== eq[i] || oh !== er[i] || odz !== 1'b0) begin
                n_fail++;
                $display("FAIL div_sign_%0d: lat=%0d lo=%h hi=%h dz=%b want 32 %h %h 0",
                         i, lat, ol, oh, odz, eq[i], er[i]);
            end
            m_hi = oh; m_lo = ol;
        end
    endtask

    task automatic test_div_zero();
        int lat; logic [31:0] oh, ol; logic odz, bok, hok, iok;
        // 0x451 / 0x20 = 0x22 remainder 0x11
        do_op(1'b1, 32'h451, 32'h20, lat, oh, ol, odz, bok, hok, iok);
        n_tests++;
        if (oh !== 32'h11 || ol !== 32'h22) begin
            n_fail++;
            $display("FAIL divz_setup: hi=%h lo=%h want 11/22", oh, ol);
        end
        do_op(1'b1, 32'd5, 32'd0, lat, oh, ol, odz, bok, hok, iok);
        n_tests++;
        if (lat !== 0) begin n_fail++; $display("FAIL divz_latency: got %0d want 0", lat); end
        n_tests++;
        if (odz !== 1'b1 || oh !== 32'h11 || ol !== 32'h22) begin
            n_fail++;
            $display("FAIL divz_result: dz=%b hi=%h lo=%h want 1 11 22", odz, oh, ol);
        end
        n_tests++;
        if (!iok) begin n_fail++; $display("FAIL divz_return_idle: idle_ok=%b want 1", iok); end
        m_hi = 32'h11; m_lo = 32'h22;
    endtask

    task automatic test_overflow();
        int lat; logic [31:0] oh, ol; logic odz, bok, hok, iok;
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, oh, ol, odz, bok, hok, iok);
        n_tests++;
        if (ol !== 32'h8000_0000 || oh !== 32'd0 || odz !== 1'b0 || lat !== 32) begin
            n_fail++;
            $display("FAIL div_overflow: lo=%h hi=%h dz=%b lat=%0d want 80000000 0 0 32",
                     ol, oh, odz, lat);
        end
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, lat, oh, ol, odz, bok, hok, iok);
        n_tests++;
        if (oh !== 32'h4000_0000 || ol !== 32'd0) begin
            n_fail++;
            $display("FAIL mult_minmin: hi=%h lo=%h want 40000000/0", oh, ol);
        end
        m_hi = oh; m_lo = ol;
    endtask

    task automatic test_random();
        int lat; logic [31:0] oh, ol; logic odz, bok, hok, iok;
        logic [31:0] ra, rb, eh, el; logic rop, edz;
        for (int i = 0; i < 40; i++) begin
            rop = 1'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = $urandom_range(1, 15);
                default: ;
            endcase
            ref_model(rop, ra, rb, m_hi, m_lo, eh, el, edz);
            do_op(rop, ra, rb, lat, oh, ol, odz, bok, hok, iok);
            n_tests++;
            if (lat !== (edz ? 0 : 32)) begin
                n_fail++;
                $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, edz ? 0 : 32);
            end
            n_tests++;
            if (oh !== eh || ol !== el || odz !== edz) begin
                n_fail++;
                $display("FAIL rand_result[%0d] op=%b a=%h b=%h: hi=%h lo=%h dz=%b want %h %h %b",
                         i, rop, ra, rb, oh, ol, odz, eh, el, edz);
            end
            n_tests++;
            if (!bok || !hok || !iok) begin
                n_fail++;
                $display("FAIL rand_protocol[%0d]: busy_ok=%b hold_ok=%b idle_ok=%b want 111",
                         i, bok, hok, iok);
            end
            m_hi = eh; m_lo = el;
        end
    endtask

    task automatic test_protocol();
        int pulses, first_c;
        logic [31:0] ph, pl, eh, el; logic edz;
        int lat; logic [31:0] oh, ol; logic odz, bok, hok, iok;
        ref_model(1'b0, 32'h0001_2345, 32'hFFFF_0F0F, m_hi, m_lo, eh, el, edz);
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'h0001_2345; b = 32'hFFFF_0F0F;
        @(posedge clk);
        #1;
        start = 1'b0;
        pulses  = 0;
        first_c = -1;
        for (int c = 1; c <= 60; c++) begin
            // Re-request during iteration 5 and during the DONE cycle.
            if (c == 5 || c == 33) begin
                start = 1'b1; op = 1'b1; a = $urandom; b = 32'd3;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                pulses++;
                if (first_c < 0) begin
                    first_c = c;
                    ph = hi;
                    pl = lo;
                end
            end
        end
        n_tests++;
        if (pulses !== 1 || first_c !== 32) begin
            n_fail++;
            $display("FAIL busy_start_ignored: pulses=%0d at=%0d want 1 at 32", pulses, first_c);
        end
        n_tests++;
        if (ph !== eh || pl !== el) begin
            n_fail++;
            $display("FAIL busy_start_result: hi=%h lo=%h want %h %h", ph, pl, eh, el);
        end
        m_hi = eh; m_lo = el;
        // Back-to-back: new start in the IDLE cycle right after done.
        ref_model(1'b1, 32'hFFFF_FC00, 32'd7, m_hi, m_lo, eh, el, edz);
        do_op(1'b0, 32'd11, 32'd13, lat, oh, ol, odz, bok, hok, iok);
        do_op(1'b1, 32'hFFFF_FC00, 32'd7, lat, oh, ol, odz, bok, hok, iok);
        n_tests++;
        if (lat !== 32 || oh !== eh || ol !== el) begin
            n_fail++;
            $display("FAIL back_to_back: lat=%0d hi=%h lo=%h want 32 %h %h", lat, oh, ol, eh, el);
        end
        m_hi = eh; m_lo = el;
    endtask

    task automatic test_reset_mid_op();
        int pulses;
        int lat; logic [31:0] oh, ol; logic odz, bok, hok, iok;
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'h1234_5678; b = 32'h0000_0100;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_midop: busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        n_tests++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL reset_abort: busy/done cycles=%0d want 0", pulses);
        end
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, oh, ol, odz, bok, hok, iok);
        n_tests++;
        if (lat !== 32 || oh !== 32'd0 || ol !== 32'd1) begin
            n_fail++;
            $display("FAIL reset_then_mult: lat=%0d hi=%h lo=%h want 32 0 1", lat, oh, ol);
        end
    endtask

    initial begin
        test_reset();
        test_directed_mult();
        test_directed_div();
        test_div_zero();
        test_overflow();
        test_random();
        test_protocol();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
